// File: rtl/wb_arbiter.sv
// -----------------------------------------------------------------------------
// wb_arbiter
//
// Round-robin arbiter that lets N_MASTERS Wishbone masters share one slave
// port. The FSM has two states. In IDLE it picks the next requester, searching
// upward from the master after the last owner. In GRANT it routes that owner's
// request to the slave combinationally and routes the slave's response back to
// the owner. Every release passes through one IDLE cycle before the next grant.
//
// Optional feature (compile-time macro):
//   WB_ARB_TIMEOUT_EN - adds a stall counter. After TIMEOUT_CYCLES strobed
//                       cycles with no slave response, the arbiter sends the
//                       owner a one-cycle error pulse and holds s_stb_o low
//                       for that cycle. When the macro is undefined there is
//                       no counter, and a stalled owner keeps the grant.
//
// Parameters:
//   N_MASTERS       number of masters (2..8)
//   TIMEOUT_CYCLES  stall limit in strobed cycles (1..65535), timeout build only
//
// Ports:
//   clk                  clock, rising edge
//   rstn_i               asynchronous active-low reset
//   m_cyc_i/m_stb_i      per-master cycle / strobe
//   m_we_i/m_lock_i      per-master write enable / bus lock
//   m_adr_i/m_dat_i      per-master address / write data (32 bits each, packed)
//   m_sel_i              per-master byte selects (4 bits each, packed)
//   m_gnt_o              one-hot grant (owner bit, GRANT state only)
//   m_ack_o/m_err_o      per-master acknowledge / error
//   m_dat_o              read data, broadcast to all masters
//   s_cyc_o..s_sel_o     slave-side request (mirror of the owner, 0 in IDLE)
//   s_dat_i/s_ack_i/s_err_i  slave response
//   owner_o              index of the current / most recent owner
//   busy_o               high while in GRANT
// -----------------------------------------------------------------------------
module wb_arbiter #(
  parameter int N_MASTERS      = 3,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                         clk,
  input  logic                         rstn_i,
  input  logic [N_MASTERS-1:0]         m_cyc_i,
  input  logic [N_MASTERS-1:0]         m_stb_i,
  input  logic [N_MASTERS-1:0]         m_we_i,
  input  logic [N_MASTERS-1:0]         m_lock_i,
  input  logic [32*N_MASTERS-1:0]      m_adr_i,
  input  logic [32*N_MASTERS-1:0]      m_dat_i,
  input  logic [4*N_MASTERS-1:0]       m_sel_i,
  output logic [N_MASTERS-1:0]         m_gnt_o,
  output logic [N_MASTERS-1:0]         m_ack_o,
  output logic [N_MASTERS-1:0]         m_err_o,
  output logic [31:0]                  m_dat_o,
  output logic                         s_cyc_o,
  output logic                         s_stb_o,
  output logic                         s_we_o,
  output logic [31:0]                  s_adr_o,
  output logic [31:0]                  s_dat_o,
  output logic [3:0]                   s_sel_o,
  input  logic [31:0]                  s_dat_i,
  input  logic                         s_ack_i,
  input  logic                         s_err_i,
  output logic [$clog2(N_MASTERS)-1:0] owner_o,
  output logic                         busy_o
);

  localparam int OW = $clog2(N_MASTERS);

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_GRANT = 1'b1
  } state_t;

  state_t        r_state;
  state_t        w_state_nxt;
  logic [OW-1:0] r_owner;
  logic [OW-1:0] w_owner_nxt;
  logic [OW-1:0] r_last_owner;
  logic [OW-1:0] w_last_owner_nxt;
  logic [OW-1:0] w_winner;

  // Owner-selected copies of the master inputs
  logic          w_own_cyc;
  logic          w_own_stb;
  logic          w_own_we;
  logic          w_own_lock;
  logic [31:0]   w_own_adr;
  logic [31:0]   w_own_dat;
  logic [3:0]    w_own_sel;
  logic [N_MASTERS-1:0] w_own_oh;
  logic          w_timeout;

  // Round-robin pick. The search starts at (last+1) mod N and wraps. The inner
  // loop keeps every bit select constant, so no index is truncated.
  function automatic logic [OW-1:0] rr_pick(input logic [N_MASTERS-1:0] req,
                                            input logic [OW-1:0]        last);
    logic [OW-1:0] pick;
    logic          found;
    int            idx;
    pick  = '0;
    found = 1'b0;
    for (int k = 1; k <= N_MASTERS; k++) begin
      idx = (int'(last) + k) % N_MASTERS;
      for (int i = 0; i < N_MASTERS; i++) begin
        if (!found && (i == idx) && req[i]) begin
          pick  = OW'(i);
          found = 1'b1;
        end
      end
    end
    return pick;
  endfunction

  assign w_winner = rr_pick(m_cyc_i, r_last_owner);

  // Owner multiplexer: selects the inputs of master r_owner
  always_comb begin
    w_own_cyc  = 1'b0;
    w_own_stb  = 1'b0;
    w_own_we   = 1'b0;
    w_own_lock = 1'b0;
    w_own_adr  = 32'h0000_0000;
    w_own_dat  = 32'h0000_0000;
    w_own_sel  = 4'h0;
    w_own_oh   = '0;
    for (int i = 0; i < N_MASTERS; i++) begin
      if (r_owner == OW'(i)) begin
        w_own_cyc   = m_cyc_i[i];
        w_own_stb   = m_stb_i[i];
        w_own_we    = m_we_i[i];
        w_own_lock  = m_lock_i[i];
        w_own_adr   = m_adr_i[i*32 +: 32];
        w_own_dat   = m_dat_i[i*32 +: 32];
        w_own_sel   = m_sel_i[i*4 +: 4];
        w_own_oh[i] = 1'b1;
      end else begin
        w_own_oh[i] = 1'b0;
      end
    end
  end

`ifdef WB_ARB_TIMEOUT_EN
  logic [15:0] r_to_cnt;

  // The pulse fires in the cycle where the count has reached the limit. That
  // cycle is the (TIMEOUT_CYCLES+1)-th strobed cycle without a response.
  assign w_timeout = (r_state == ST_GRANT) && (r_to_cnt == 16'(TIMEOUT_CYCLES));

  // Stall counter: counts strobed cycles with no response. It clears on a
  // response, on release, or after it fires.
  always_ff @(posedge clk or negedge rstn_i) begin
    if (!rstn_i) begin
      r_to_cnt <= 16'd0;
    end else if ((r_state != ST_GRANT) || (w_state_nxt == ST_IDLE) ||
                 w_timeout || s_ack_i || s_err_i) begin
      r_to_cnt <= 16'd0;
    end else if (w_own_stb) begin
      r_to_cnt <= r_to_cnt + 16'd1;
    end else begin
      r_to_cnt <= r_to_cnt;
    end
  end
`else
  assign w_timeout = 1'b0;
`endif

  // FSM state, owner and last-owner registers
  always_ff @(posedge clk or negedge rstn_i) begin
    if (!rstn_i) begin
      r_state      <= ST_IDLE;
      r_owner      <= '0;
      r_last_owner <= OW'(N_MASTERS - 1);
    end else begin
      r_state      <= w_state_nxt;
      r_owner      <= w_owner_nxt;
      r_last_owner <= w_last_owner_nxt;
    end
  end

  // Next-state logic. A release always passes through IDLE, so the same
  // master can never be regranted back to back.
  always_comb begin
    w_state_nxt      = r_state;
    w_owner_nxt      = r_owner;
    w_last_owner_nxt = r_last_owner;
    case (r_state)
      ST_IDLE: begin
        if (|m_cyc_i) begin
          w_state_nxt = ST_GRANT;
          w_owner_nxt = w_winner;
        end else begin
          w_state_nxt = ST_IDLE;
        end
      end
      ST_GRANT: begin
        if (w_own_cyc || w_own_lock) begin
          w_state_nxt = ST_GRANT;
        end else begin
          w_state_nxt      = ST_IDLE;
          w_last_owner_nxt = r_owner;
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  // Output decode. The slave request and the responses pass only in GRANT.
  // In IDLE, slave responses are dropped.
  always_comb begin
    m_gnt_o = '0;
    m_ack_o = '0;
    m_err_o = '0;
    s_cyc_o = 1'b0;
    s_stb_o = 1'b0;
    s_we_o  = 1'b0;
    s_adr_o = 32'h0000_0000;
    s_dat_o = 32'h0000_0000;
    s_sel_o = 4'h0;
    busy_o  = 1'b0;
    if (r_state == ST_GRANT) begin
      busy_o  = 1'b1;
      m_gnt_o = w_own_oh;
      m_ack_o = w_own_oh & {N_MASTERS{s_ack_i & w_own_stb}};
      m_err_o = w_own_oh & {N_MASTERS{(s_err_i & w_own_stb) | w_timeout}};
      s_cyc_o = w_own_cyc;
      s_stb_o = w_own_stb & ~w_timeout;
      s_we_o  = w_own_we;
      s_adr_o = w_own_adr;
      s_dat_o = w_own_dat;
      s_sel_o = w_own_sel;
    end else begin
      busy_o  = 1'b0;
    end
  end

  assign owner_o = r_owner;
  assign m_dat_o = s_dat_i;

endmodule

// File: doc/wb_arbiter.md
WB_ARBITER -- requirements
Module: wb_arbiter

Interface
REQ-001 SHALL have parameter: N_MASTERS, 3, number of Wishbone masters sharing one slave port (2..8).
REQ-002 SHALL have parameter: TIMEOUT_CYCLES, 255, maximum strobed-without-response cycles before forced error (1..65535).
REQ-003 SHALL have port: clk  input  1  clock, rising edge.
REQ-004 SHALL have port: rstn_i  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have ports, per master: m_cyc_i, m_stb_i, m_we_i, m_lock_i  input  N_MASTERS  cycle, strobe, write, lock.
REQ-006 SHALL have ports: m_adr_i  input  32*N_MASTERS  address; m_dat_i  input  32*N_MASTERS  write data; m_sel_i  input  4*N_MASTERS  byte selects.
REQ-007 SHALL have ports: m_gnt_o, m_ack_o, m_err_o  output  N_MASTERS  grant, acknowledge, error.
REQ-008 SHALL have port: m_dat_o  output  32  read data, broadcast to all masters.
REQ-009 SHALL have ports: s_cyc_o, s_stb_o, s_we_o  output  1; s_adr_o, s_dat_o  output  32; s_sel_o  output  4  slave-side request.
REQ-010 SHALL have ports: s_dat_i  input  32; s_ack_i, s_err_i  input  1  slave response.
REQ-011 SHALL have port: owner_o  output  $clog2(N_MASTERS)  index of current owner; busy_o  output  1  high in GRANT.

Function
REQ-012 SHALL implement FSM with states IDLE and GRANT.
REQ-013 IDLE: if any m_cyc_i bit high, SHALL select winner round-robin, searching from (last_owner+1) mod N_MASTERS upward with wrap, register owner, go to GRANT; else stay IDLE.
REQ-014 Grant latency SHALL be exactly one cycle: m_cyc_i sampled at edge t, m_gnt_o[owner] high from cycle after edge t.
REQ-015 GRANT: m_gnt_o SHALL be one-hot on owner; all other bits 0; busy_o=1.
REQ-016 GRANT: s_cyc_o, s_stb_o, s_we_o, s_adr_o, s_dat_o, s_sel_o SHALL combinationally mirror the owner's inputs; in IDLE all SHALL be 0.
REQ-017 m_ack_o[owner] SHALL equal s_ack_i & m_stb_i[owner] & GRANT; non-owner ack bits SHALL be 0.
REQ-018 m_err_o[owner] SHALL equal s_err_i & m_stb_i[owner] & GRANT, OR the timeout pulse (REQ-027).
REQ-019 m_dat_o SHALL equal s_dat_i unconditionally.
REQ-020 GRANT SHALL be held while m_cyc_i[owner] or m_lock_i[owner] is high; when both low at a clock edge, SHALL go to IDLE and set last_owner=owner.
REQ-021 After release SHALL spend one cycle in IDLE before next grant (no back-to-back handover), including the same master re-requesting.
REQ-022 Requests from non-owners during GRANT SHALL be ignored and held pending; no starvation: each requester granted within N_MASTERS grants.
REQ-023 Owner dropping m_cyc_i with m_stb_i high and m_lock_i low SHALL release at that edge; no ack delivered for the abandoned strobe.
REQ-024 s_ack_i or s_err_i while in IDLE SHALL be discarded.

Reset
REQ-025 On rstn_i low SHALL immediately force: state IDLE, last_owner=N_MASTERS-1 (master 0 wins first), owner_o=0, busy_o=0, m_gnt_o=0, m_ack_o=0, m_err_o=0, s_cyc_o=0, s_stb_o=0, timeout counter 0.
REQ-026 Reset asserted mid-transaction SHALL drop grant and s_cyc_o in the same cycle; no response delivered after release of reset.

Configuration
REQ-027 With WB_ARB_TIMEOUT_EN defined: counter SHALL increment each GRANT cycle with s_stb_o=1 and s_ack_i=s_err_i=0, clear on ack/err/release; at count TIMEOUT_CYCLES SHALL pulse m_err_o[owner] for one cycle, drive s_stb_o=0 that cycle, clear counter.
REQ-028 Without WB_ARB_TIMEOUT_EN: no counter SHALL exist; m_err_o SHALL reflect only s_err_i per REQ-018; stalled transactions hold grant indefinitely.

Verification
REQ-029 Masters 0,1,2 assert m_cyc_i together after reset -> grants in order 0,1,2, each preceded by one IDLE cycle.
REQ-030 Master 1 holds m_lock_i=1 with m_cyc_i toggling low one cycle -> grant retained, master 0 request pending until lock drops.
REQ-031 Owner 2 writes adr 0x1000, dat 0xDEADBEEF, sel 0xF; slave acks after 3 cycles -> s_* mirror values, m_ack_o=3'b100 for exactly one cycle.
REQ-032 Slave never responds, TIMEOUT_CYCLES=4, macro defined -> m_err_o[owner] pulses on 5th strobed cycle; macro undefined -> grant held, no err.
REQ-033 rstn_i asserted during active grant -> m_gnt_o and s_cyc_o 0 same cycle; after release master 0 wins first.
REQ-034 Single master 0 issues repeated transactions -> granted each time, one IDLE cycle between releases and re-grants.
